kv_hash_table: RTL and testbench
================================

KV_HASH_TABLE -- requirements
Module: kv_hash_table

Interface
REQ-001 SHALL have parameter HASH_SIZE, default 32, request hash width.
REQ-002 SHALL have parameter KEY_SIZE, default 96, key width.
REQ-003 SHALL have parameter VAL_SIZE, default 32, value width.
REQ-004 SHALL have parameter IDX_BITS, default 8, set-index width; sets = 2**IDX_BITS; IDX_BITS <= HASH_SIZE.
REQ-005 SHALL have parameter WAYS, default 4, associativity; WAYS is a power of two, 1..8.
REQ-006 SHALL have parameter TS_BITS, default 16, timestamp width.
REQ-007 SHALL have parameter TICK_DIV_BITS, default 24, timestamp tick = 2**TICK_DIV_BITS clocks.
REQ-008 SHALL have parameter TTL, default 16'd3600, maximum entry age in ticks.
REQ-009 Ports: clk156 in 1, sole clock. Reset is asynchronous, active-low: rst_n in 1.
REQ-010 Ports: in_valid in 1, request strobe; in_ready out 1, request accepted when in_valid && in_ready.
REQ-011 Ports: in_op in 4 (0 GET, 1 SET, 2 DEL); in_hash in HASH_SIZE; in_key in KEY_SIZE; in_value in VAL_SIZE.
REQ-012 Ports: out_valid out 1, single-cycle response strobe; out_flag out 4; out_value out VAL_SIZE.

Function
REQ-013 Set index SHALL be in_hash[IDX_BITS-1:0]; each way entry holds {valid, key, value, ts}.
REQ-014 FSM states INIT, IDLE, RD, CMP, WR; in_ready=1 only in IDLE.
REQ-015 INIT SHALL clear valid of one set per cycle, index 0 to 2**IDX_BITS-1, then go to IDLE; INIT takes exactly 2**IDX_BITS cycles.
REQ-016 Accept in IDLE -> RD (issue read of all ways) -> CMP (compare, decide) -> WR -> IDLE; request fields latched at acceptance.
REQ-017 out_valid SHALL pulse in the WR cycle, exactly 3 cycles after the accepting edge, for every accepted op; max throughput one op per 4 cycles.
REQ-018 Hit = valid && key equal && not expired; multiple matches resolve to lowest way index.
REQ-019 Expired = ((now_ts - entry_ts) mod 2**TS_BITS) > TTL; expired entries behave as invalid.
REQ-020 out_flag bits: [0] hit, [1] written, [2] valid unexpired entry evicted, [3] expired entry encountered in the set.
REQ-021 GET: out_value = hit value, else 0; no table write.
REQ-022 SET hit: overwrite value, refresh ts to now_ts, flag[1]=1, flag[0]=1.
REQ-023 SET miss: write lowest-index invalid/expired way; if none, write way victim_ptr, flag[2]=1, victim_ptr increments modulo WAYS; flag[1]=1.
REQ-024 DEL: hit clears valid, flag[0]=1, flag[1]=1; miss writes nothing, flag=0.
REQ-025 Undefined in_op: out_valid pulses with out_flag=0, out_value=0, no write.
REQ-026 now_ts SHALL increment once per 2**TICK_DIV_BITS clocks and wrap from all-ones to 0.
REQ-027 out_flag and out_value SHALL be 0 whenever out_valid=0.

Reset
REQ-028 On rst_n low, asynchronously: state=INIT, in_ready=0, out_valid=0, out_flag=0, out_value=0, now_ts=0, tick divider=0, victim_ptr=0, latched request=0.
REQ-029 Reset mid-operation SHALL abandon the op with no response and restart INIT on release.
REQ-030 Table RAM contents need no reset; valid bits are cleared by INIT.

Structure
REQ-031 Shared package kv_pkg SHALL hold opcode constants, out_flag bit positions and FSM state encoding.
REQ-032 One sub-module kv_way_ram (synchronous, one read port, one write port, 2**IDX_BITS deep) SHALL be instantiated once per way via generate.

Verification
REQ-033 Reset release -> in_ready=0 for 256 cycles (IDX_BITS=8), then 1.
REQ-034 SET key=0xA5, value=0x1234, then GET key=0xA5 -> out_flag=0001, out_value=0x1234, 3 cycles after accept.
REQ-035 5 SETs of distinct keys into one set (WAYS=4) -> fifth out_flag=0110; GET of first key -> out_flag=0000.
REQ-036 DEL existing key -> flag=0011; repeat GET -> flag=0000, out_value=0.
REQ-037 TICK_DIV_BITS=2, TTL=3: SET, wait 20 cycles, GET -> flag=1000; SET other key same set reuses that way, flag[2]=0.
REQ-038 Assert rst_n low during CMP -> no out_valid; after release INIT reruns, GET of prior key misses.

Source files
------------

// File: rtl/kv_pkg.sv
// Shared definitions for the kv_hash_table slice: request opcodes, the bit
// positions inside out_flag, and the controller state encoding.
package kv_pkg;

  localparam logic [3:0] OP_GET = 4'd0;
  localparam logic [3:0] OP_SET = 4'd1;
  localparam logic [3:0] OP_DEL = 4'd2;

  localparam int unsigned FLAG_HIT     = 0;  // key found in a live entry
  localparam int unsigned FLAG_WRITTEN = 1;  // table was modified
  localparam int unsigned FLAG_EVICT   = 2;  // a live entry was displaced
  localparam int unsigned FLAG_EXPIRED = 3;  // an aged-out entry sits in the set

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_WR
  } kv_state_e;

endpackage

// File: rtl/kv_way_ram.sv
// One way of the hash table: simple dual-port storage, synchronous read with
// one cycle latency, synchronous write. Contents are not reset.
//   clk156  : clock
//   rd_en   : latch mem[rd_addr] into rd_data on the next edge
//   rd_addr : read index
//   rd_data : registered read data
//   wr_en   : write wr_data into mem[wr_addr] on the next edge
//   wr_addr : write index
//   wr_data : write data
module kv_way_ram #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk156,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk156) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/kv_hash_table.sv
// Set-associative key/value table with per-entry timestamps and TTL ageing.
// One request at a time: IDLE accepts, RD reads every way of the set, CMP
// decides, WR performs the write and presents the one-cycle response.
//   clk156, rst_n        : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (ready only in IDLE)
//   in_op                : 0 GET, 1 SET, 2 DEL, others answered with flag 0
//   in_hash              : low IDX_BITS select the set
//   in_key / in_value    : request key and value
//   out_valid            : single-cycle response strobe
//   out_flag             : [0] hit [1] written [2] evicted [3] expired seen
//   out_value            : GET hit value, otherwise 0
module kv_hash_table
  import kv_pkg::*;
#(
  parameter int unsigned         HASH_SIZE     = 32,
  parameter int unsigned         KEY_SIZE      = 96,
  parameter int unsigned         VAL_SIZE      = 32,
  parameter int unsigned         IDX_BITS      = 8,
  parameter int unsigned         WAYS          = 4,
  parameter int unsigned         TS_BITS       = 16,
  parameter int unsigned         TICK_DIV_BITS = 24,
  parameter logic [TS_BITS-1:0]  TTL           = 16'd3600
) (
  input  logic                 clk156,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [HASH_SIZE-1:0] in_hash,
  input  logic [KEY_SIZE-1:0]  in_key,
  input  logic [VAL_SIZE-1:0]  in_value,
  output logic                 out_valid,
  output logic [3:0]           out_flag,
  output logic [VAL_SIZE-1:0]  out_value
);

  localparam int unsigned EW = 1 + KEY_SIZE + VAL_SIZE + TS_BITS;
  localparam int unsigned WB = (WAYS > 1) ? $clog2(WAYS) : 1;

  kv_state_e state, state_nx;

  logic [IDX_BITS-1:0]      init_idx;
  logic [TICK_DIV_BITS-1:0] tick_div;
  logic [TS_BITS-1:0]       now_ts;
  logic [WB-1:0]            victim_ptr;

  logic [3:0]               req_op;
  logic [IDX_BITS-1:0]      req_idx;
  logic [KEY_SIZE-1:0]      req_key;
  logic [VAL_SIZE-1:0]      req_value;

  logic [WAYS-1:0]          wr_mask;
  logic [EW-1:0]            wr_entry;

  logic                     ram_re;
  logic [WAYS-1:0]          ram_we;
  logic [IDX_BITS-1:0]      ram_waddr;
  logic [EW-1:0]            ram_wdata;
  logic [EW-1:0]            rd_data [WAYS];

  logic [WAYS-1:0]          way_live;
  logic [WAYS-1:0]          way_match;
  logic [WAYS-1:0]          way_stale;
  logic [VAL_SIZE-1:0]      way_val [WAYS];

  logic                     hit_any, free_any, exp_any;
  logic [WB-1:0]            hit_way, free_way;
  logic [VAL_SIZE-1:0]      hit_val;

  logic [3:0]               dec_flag;
  logic [VAL_SIZE-1:0]      dec_value;
  logic [WAYS-1:0]          dec_mask;
  logic [EW-1:0]            dec_entry;
  logic                     dec_evict;

  // Only the set index is taken from the hash.
  logic hash_unused;
  assign hash_unused = ^in_hash;

  // Entry layout: {valid, key, value, ts}
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TS_BITS-1:0] age;
    logic               valid;

    kv_way_ram #(
      .ADDR_BITS (IDX_BITS),
      .DATA_BITS (EW)
    ) u_ram (
      .clk156  (clk156),
      .rd_en   (ram_re),
      .rd_addr (req_idx),
      .rd_data (rd_data[w]),
      .wr_en   (ram_we[w]),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata)
    );

    assign valid        = rd_data[w][EW-1];
    // Modular subtraction handles timestamp wrap.
    assign age          = now_ts - rd_data[w][TS_BITS-1:0];
    assign way_stale[w] = valid && (age > TTL);
    assign way_live[w]  = valid && !(age > TTL);
    assign way_match[w] = way_live[w] &&
                          (rd_data[w][TS_BITS+VAL_SIZE +: KEY_SIZE] == req_key);
    assign way_val[w]   = rd_data[w][TS_BITS +: VAL_SIZE];
  end

  // Lowest-index hit and lowest-index reusable way.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    hit_val  = '0;
    free_any = 1'b0;
    free_way = '0;
    exp_any  = |way_stale;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_match[w] && !hit_any) begin
        hit_any = 1'b1;
        hit_way = WB'(w);
        hit_val = way_val[w];
      end
      if (!way_live[w] && !free_any) begin
        free_any = 1'b1;
        free_way = WB'(w);
      end
    end
  end

  always_comb begin
    dec_flag  = '0;
    dec_value = '0;
    dec_mask  = '0;
    dec_entry = '0;
    dec_evict = 1'b0;
    case (req_op)
      OP_GET: begin
        dec_flag[FLAG_HIT]     = hit_any;
        dec_flag[FLAG_EXPIRED] = exp_any;
        dec_value              = hit_any ? hit_val : '0;
      end
      OP_SET: begin
        dec_flag[FLAG_HIT]     = hit_any;
        dec_flag[FLAG_WRITTEN] = 1'b1;
        dec_flag[FLAG_EXPIRED] = exp_any;
        dec_entry              = {1'b1, req_key, req_value, now_ts};
        if (hit_any) begin
          dec_mask = WAYS'(1) << hit_way;
        end else if (free_any) begin
          dec_mask = WAYS'(1) << free_way;
        end else begin
          dec_mask             = WAYS'(1) << victim_ptr;
          dec_evict            = 1'b1;
          dec_flag[FLAG_EVICT] = 1'b1;
        end
      end
      OP_DEL: begin
        dec_flag[FLAG_EXPIRED] = exp_any;
        if (hit_any) begin
          dec_flag[FLAG_HIT]     = 1'b1;
          dec_flag[FLAG_WRITTEN] = 1'b1;
          dec_mask               = WAYS'(1) << hit_way;
        end
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT: if (init_idx == '1) state_nx = ST_IDLE;
      ST_IDLE: if (in_valid) state_nx = ST_RD;
      ST_RD:   state_nx = ST_CMP;
      ST_CMP:  state_nx = ST_WR;
      ST_WR:   state_nx = ST_IDLE;
      default: state_nx = ST_INIT;
    endcase
  end

  // Output / RAM control
  always_comb begin
    in_ready  = (state == ST_IDLE);
    ram_re    = (state == ST_RD);
    ram_we    = '0;
    ram_waddr = req_idx;
    ram_wdata = wr_entry;
    if (state == ST_INIT) begin
      ram_we    = '1;
      ram_waddr = init_idx;
      ram_wdata = '0;
    end else if (state == ST_WR) begin
      ram_we = wr_mask;
    end
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      init_idx   <= '0;
      tick_div   <= '0;
      now_ts     <= '0;
      victim_ptr <= '0;
      req_op     <= '0;
      req_idx    <= '0;
      req_key    <= '0;
      req_value  <= '0;
      wr_mask    <= '0;
      wr_entry   <= '0;
      out_valid  <= 1'b0;
      out_flag   <= '0;
      out_value  <= '0;
    end else begin
      tick_div <= tick_div + 1'b1;
      if (&tick_div) now_ts <= now_ts + 1'b1;

      if (state == ST_INIT) init_idx <= init_idx + 1'b1;

      if (in_valid && in_ready) begin
        req_op    <= in_op;
        req_idx   <= in_hash[IDX_BITS-1:0];
        req_key   <= in_key;
        req_value <= in_value;
      end

      // Decision is registered at the CMP->WR edge so the response and the
      // table write both happen in the WR cycle.
      if (state == ST_CMP) begin
        out_valid <= 1'b1;
        out_flag  <= dec_flag;
        out_value <= dec_value;
        wr_mask   <= dec_mask;
        wr_entry  <= dec_entry;
        if (dec_evict) victim_ptr <= (WAYS > 1) ? victim_ptr + 1'b1 : '0;
      end else begin
        out_valid <= 1'b0;
        out_flag  <= '0;
        out_value <= '0;
      end
    end
  end

endmodule

// File: tb/tb_kv_hash_table.sv
module tb_kv_hash_table;

  localparam logic [3:0] GET = 4'd0;
  localparam logic [3:0] SET = 4'd1;
  localparam logic [3:0] DEL = 4'd2;

  logic        clk156 = 1'b0;
  logic        rst_n;
  logic [3:0]  in_op;
  logic [31:0] in_hash;
  logic [95:0] in_key;
  logic [31:0] in_value;

  logic        in_valid_a, in_ready_a, out_valid_a;
  logic [3:0]  out_flag_a;
  logic [31:0] out_value_a;
  logic        in_valid_b, in_ready_b, out_valid_b;
  logic [3:0]  out_flag_b;
  logic [31:0] out_value_b;

  int total = 0;
  int bad   = 0;
  logic [3:0]  rsp_flag;
  logic [31:0] rsp_value;

  always #5 clk156 = ~clk156;

  // Default configuration: timestamps effectively frozen for this run.
  kv_hash_table dut_a (
    .clk156    (clk156),
    .rst_n     (rst_n),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_op     (in_op),
    .in_hash   (in_hash),
    .in_key    (in_key),
    .in_value  (in_value),
    .out_valid (out_valid_a),
    .out_flag  (out_flag_a),
    .out_value (out_value_a)
  );

  // Fast ageing: one tick per 4 clocks, entries expire after 3 ticks.
  kv_hash_table #(
    .TICK_DIV_BITS (2),
    .TTL           (16'd3)
  ) dut_b (
    .clk156    (clk156),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_op     (in_op),
    .in_hash   (in_hash),
    .in_key    (in_key),
    .in_value  (in_value),
    .out_valid (out_valid_b),
    .out_flag  (out_flag_b),
    .out_value (out_value_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, check the response arrives in the third cycle after
  // acceptance as a single-cycle pulse, and capture flag/value.
  task automatic do_op(input bit sel, input logic [3:0] op, input logic [31:0] hash,
                       input logic [95:0] key, input logic [31:0] val);
    int   n;
    logic rdy;
    logic [3:0] pv;
    logic quiet_bad;
    n = 0;
    quiet_bad = 1'b0;
    @(negedge clk156);
    rdy = sel ? in_ready_b : in_ready_a;
    while (!rdy && n < 2000) begin
      @(negedge clk156);
      n++;
      rdy = sel ? in_ready_b : in_ready_a;
    end
    chk("ready_wait", {31'b0, rdy}, 32'd1);
    in_op = op; in_hash = hash; in_key = key; in_value = val;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk156);
    #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk156);
      pv[i] = sel ? out_valid_b : out_valid_a;
      if (i == 2) begin
        rsp_flag  = sel ? out_flag_b : out_flag_a;
        rsp_value = sel ? out_value_b : out_value_a;
      end else if (sel ? (out_flag_b != 4'd0 || out_value_b != 32'd0)
                       : (out_flag_a != 4'd0 || out_value_a != 32'd0)) begin
        quiet_bad = 1'b1;
      end
    end
    chk("rsp_timing", {28'b0, pv}, 32'b0100);
    chk("outputs_zero_when_idle", {31'b0, quiet_bad}, 32'd0);
  endtask

  task automatic expect_rsp(input string tag, input logic [3:0] flag, input logic [31:0] value);
    chk({tag, "_flag"}, {28'b0, rsp_flag}, {28'b0, flag});
    chk({tag, "_value"}, rsp_value, value);
  endtask

  initial begin
    int n;
    int pulses;
    rst_n = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_op = '0; in_hash = '0; in_key = '0; in_value = '0;
    repeat (3) @(negedge clk156);
    chk("rst_in_ready", {31'b0, in_ready_a}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
    chk("rst_out_flag", {28'b0, out_flag_a}, 32'd0);
    chk("rst_out_value", out_value_a, 32'd0);

    // INIT sweeps 256 sets
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk156);
      n++;
    end while (!in_ready_a && n < 1000);
    chk("init_cycles", n, 32'd256);
    chk("init_b_ready", {31'b0, in_ready_b}, 32'd1);

    // Basic SET / GET / overwrite
    do_op(0, SET, 32'h10, 96'hA5, 32'h1234);   expect_rsp("set_a5", 4'b0010, 32'h0);
    do_op(0, GET, 32'h10, 96'hA5, 32'h0);      expect_rsp("get_a5", 4'b0001, 32'h1234);
    do_op(0, SET, 32'h10, 96'hA5, 32'h5678);   expect_rsp("reset_a5", 4'b0011, 32'h0);
    do_op(0, GET, 32'h10, 96'hA5, 32'h0);      expect_rsp("get_a5_new", 4'b0001, 32'h5678);
    do_op(0, GET, 32'h10, 96'hA6, 32'h0);      expect_rsp("get_miss", 4'b0000, 32'h0);
    do_op(0, SET, 32'h0, 96'h0, 32'hFFFF_FFFF); expect_rsp("set_zero_key", 4'b0010, 32'h0);
    do_op(0, GET, 32'h100, 96'h0, 32'h0);      expect_rsp("get_zero_key", 4'b0001, 32'hFFFF_FFFF);

    // Fill set 0x20 (upper hash bits ignored) and overflow it
    do_op(0, SET, 32'h20,       96'h1, 32'h101); expect_rsp("fill1", 4'b0010, 32'h0);
    do_op(0, SET, 32'h120,      '1,    32'h102); expect_rsp("fill2", 4'b0010, 32'h0);
    do_op(0, SET, 32'hFFFFFF20, 96'h3, 32'h103); expect_rsp("fill3", 4'b0010, 32'h0);
    do_op(0, SET, 32'h7720, 96'h8000_0000_0000_0000_0000_0000, 32'h104);
    expect_rsp("fill4", 4'b0010, 32'h0);
    do_op(0, SET, 32'h20, 96'h5, 32'h105);       expect_rsp("evict1", 4'b0110, 32'h0);
    do_op(0, GET, 32'h20, 96'h1, 32'h0);         expect_rsp("get_evicted1", 4'b0000, 32'h0);
    do_op(0, SET, 32'h20, 96'h6, 32'h106);       expect_rsp("evict2", 4'b0110, 32'h0);
    do_op(0, GET, 32'h20, '1, 32'h0);            expect_rsp("get_evicted2", 4'b0000, 32'h0);
    do_op(0, GET, 32'h20, 96'h3, 32'h0);         expect_rsp("get_k3", 4'b0001, 32'h103);
    do_op(0, GET, 32'h20, 96'h5, 32'h0);         expect_rsp("get_k5", 4'b0001, 32'h105);

    // Delete
    do_op(0, DEL, 32'h20, 96'h3, 32'h0);         expect_rsp("del_k3", 4'b0011, 32'h0);
    do_op(0, GET, 32'h20, 96'h3, 32'h0);         expect_rsp("get_deleted", 4'b0000, 32'h0);
    do_op(0, DEL, 32'h20, 96'h3, 32'h0);         expect_rsp("del_miss", 4'b0000, 32'h0);
    do_op(0, SET, 32'h20, 96'h7, 32'h107);       expect_rsp("set_into_hole", 4'b0010, 32'h0);
    do_op(0, GET, 32'h20, 96'h7, 32'h0);         expect_rsp("get_k7", 4'b0001, 32'h107);

    // Undefined opcodes
    do_op(0, 4'd3, 32'h10, 96'hA5, 32'h0);       expect_rsp("op3", 4'b0000, 32'h0);
    do_op(0, 4'hF, 32'h10, 96'hA5, 32'h0);       expect_rsp("opF", 4'b0000, 32'h0);
    do_op(0, GET, 32'h10, 96'hA5, 32'h0);        expect_rsp("get_after_undef", 4'b0001, 32'h5678);

    // Ageing on the fast-tick instance
    do_op(1, SET, 32'h33, 96'hB1, 32'hAAAA);     expect_rsp("ttl_set", 4'b0010, 32'h0);
    repeat (20) @(negedge clk156);
    do_op(1, GET, 32'h33, 96'hB1, 32'h0);        expect_rsp("ttl_expired", 4'b1000, 32'h0);
    do_op(1, SET, 32'h33, 96'hB2, 32'hBBBB);     expect_rsp("ttl_reuse", 4'b1010, 32'h0);
    do_op(1, GET, 32'h33, 96'hB2, 32'h0);        expect_rsp("ttl_get_new", 4'b0001, 32'hBBBB);
    do_op(1, GET, 32'h33, 96'hB1, 32'h0);        expect_rsp("ttl_old_gone", 4'b0000, 32'h0);

    // Reset while a GET is in CMP
    n = 0;
    @(negedge clk156);
    while (!in_ready_a && n < 100) begin
      @(negedge clk156);
      n++;
    end
    in_op = GET; in_hash = 32'h10; in_key = 96'hA5; in_value = '0;
    in_valid_a = 1'b1;
    @(posedge clk156);
    #1;
    in_valid_a = 1'b0;
    @(negedge clk156);      // RD
    @(negedge clk156);      // CMP
    rst_n = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk156);
      if (out_valid_a) pulses++;
    end
    chk("rst_mid_op_no_rsp", pulses, 32'd0);
    chk("rst_mid_op_ready", {31'b0, in_ready_a}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    pulses = 0;
    do begin
      @(negedge clk156);
      n++;
      if (out_valid_a) pulses++;
    end while (!in_ready_a && n < 1000);
    chk("reinit_cycles", n, 32'd256);
    chk("reinit_no_rsp", pulses, 32'd0);
    do_op(0, GET, 32'h10, 96'hA5, 32'h0);        expect_rsp("get_after_reset", 4'b0000, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
